// File: rtl/led_racer_pkg.sv
// led_racer_pkg: shared FSM state, GRB word width and colour constants for the LED strip renderer
package led_racer_pkg;
  typedef enum logic [1:0] {IDLE, LATCH, SEND, GAP} state_t;
  localparam int GRB_W = 24;
  localparam logic [GRB_W-1:0] GRB_RED    = 24'h004000;
  localparam logic [GRB_W-1:0] GRB_BLUE   = 24'h000040;
  localparam logic [GRB_W-1:0] GRB_GREEN  = 24'h400000;
  localparam logic [GRB_W-1:0] GRB_YELLOW = 24'h404000;
  localparam logic [GRB_W-1:0] GRB_WHITE  = 24'h404040;
  localparam logic [GRB_W-1:0] GRB_OFF    = 24'h000000;
  function automatic logic [GRB_W-1:0] player_color(input logic [1:0] p);
    return p == 2'd0 ? GRB_RED : p == 2'd1 ? GRB_BLUE : p == 2'd2 ? GRB_GREEN : GRB_YELLOW;
  endfunction
endpackage

// File: rtl/ws2812_bit_tx.sv
// ws2812_bit_tx: drives one WS2812 bit waveform per start, done pulses on the bit's last clock
module ws2812_bit_tx #(
  parameter int BIT_CLK_COUNT = 62,
  parameter int T0H_CLK_COUNT = 20,
  parameter int T1H_CLK_COUNT = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_in,
  output logic data,
  output logic done
);
  localparam int CW = $clog2(BIT_CLK_COUNT);
  logic [CW-1:0] cnt;
  logic active;
  assign done = active && cnt == CW'(BIT_CLK_COUNT - 1);
  // bit_in is held by the caller for the whole bit, so the high time follows it directly
  assign data = active && cnt < (bit_in ? CW'(T1H_CLK_COUNT) : CW'(T0H_CLK_COUNT));
  always_ff @(posedge clk)
    if (reset) begin
      active <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt <= '0;
    end else if (done)
      active <= 1'b0;
    else if (active)
      cnt <= cnt + CW'(1);
endmodule

// File: rtl/led_strip_renderer.sv
// led_strip_renderer: snapshots game state on refresh and streams one GRB frame onto a WS2812 line
// Define LED_COLOR_BLEND_EN to OR overlapping players instead of fixed red>blue>green>yellow priority.
module led_strip_renderer
  import led_racer_pkg::*;
#(
  parameter int MAX_POS         = 16,
  parameter int BIT_CLK_COUNT   = 62,
  parameter int T0H_CLK_COUNT   = 20,
  parameter int T1H_CLK_COUNT   = 40,
  parameter int RESET_CLK_COUNT = 2500
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(MAX_POS)-1:0] red_cur_pos,
  input  logic [$clog2(MAX_POS)-1:0] blue_cur_pos,
  input  logic [$clog2(MAX_POS)-1:0] green_cur_pos,
  input  logic [$clog2(MAX_POS)-1:0] yellow_cur_pos,
  input  logic                       red_ready_to_play,
  input  logic                       blue_ready_to_play,
  input  logic                       green_ready_to_play,
  input  logic                       yellow_ready_to_play,
  input  logic                       is_in_menu,
  input  logic [2:0]                 countdown,
  input  logic                       refresh,
  output logic                       led_data,
  output logic                       busy
);
  localparam int POS_W = $clog2(MAX_POS);
  localparam int GAP_W = $clog2(RESET_CLK_COUNT);
  state_t state;
  logic pending, done, start, bit_in, last_bit, go;
  logic [4:0] bit_idx;
  logic [POS_W-1:0] led_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic [POS_W-1:0] pos_q [4];
  logic [3:0] rdy_q;
  logic menu_q;
  logic [2:0] cd_q;
  logic [GRB_W-1:0] race_word, menu_word;
  always_ff @(posedge clk)
    if (state == LATCH) begin
      pos_q <= '{red_cur_pos, blue_cur_pos, green_cur_pos, yellow_cur_pos};
      rdy_q <= {yellow_ready_to_play, green_ready_to_play, blue_ready_to_play, red_ready_to_play};
      menu_q <= is_in_menu;
      cd_q <= countdown;
    end
  // scanning yellow first lets red overwrite last when priority is fixed
  always_comb begin
    race_word = GRB_OFF;
    for (int k = 3; k >= 0; k--)
      if (pos_q[k] == led_idx)
`ifdef LED_COLOR_BLEND_EN
        race_word = race_word | player_color(2'(k));
`else
        race_word = player_color(2'(k));
`endif
  end
  assign menu_word = int'(led_idx) + int'(cd_q) >= MAX_POS ? GRB_WHITE :
                     int'(led_idx) < 4 && rdy_q[led_idx[1:0]] ? player_color(led_idx[1:0]) : GRB_OFF;
  assign bit_in = menu_q ? menu_word[bit_idx] : race_word[bit_idx];
  assign last_bit = bit_idx == '0 && led_idx == POS_W'(MAX_POS - 1);
  assign start = state == LATCH || (state == SEND && done && !last_bit);
  assign go = pending || refresh;
  always_ff @(posedge clk)
    if (reset) begin
      state <= GAP;
      busy <= 1'b0;
      pending <= 1'b0;
      gap_cnt <= '0;
      led_idx <= '0;
      bit_idx <= '0;
    end else
      case (state)
        IDLE: begin
          state <= refresh ? LATCH : IDLE;
          busy <= refresh;
        end
        LATCH: begin
          state <= SEND;
          pending <= refresh;
          led_idx <= '0;
          bit_idx <= 5'(GRB_W - 1);
        end
        SEND: begin
          pending <= go;
          if (done) begin
            state <= last_bit ? GAP : SEND;
            led_idx <= bit_idx == '0 && !last_bit ? led_idx + POS_W'(1) : led_idx;
            bit_idx <= bit_idx == '0 ? 5'(GRB_W - 1) : bit_idx - 5'd1;
          end
        end
        GAP:
          if (!busy) begin
            busy <= 1'b1;
            pending <= go;
          end else if (gap_cnt == GAP_W'(RESET_CLK_COUNT - 1)) begin
            state <= go ? LATCH : IDLE;
            busy <= go;
            pending <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
            pending <= go;
          end
      endcase
  ws2812_bit_tx #(
    .BIT_CLK_COUNT(BIT_CLK_COUNT),
    .T0H_CLK_COUNT(T0H_CLK_COUNT),
    .T1H_CLK_COUNT(T1H_CLK_COUNT)
  ) u_tx (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bit_in(bit_in),
    .data(led_data),
    .done(done)
  );
endmodule

// File: tb/tb_led_strip_renderer.sv
// tb_led_strip_renderer: decodes the WS2812 line and checks frames against a behavioural model
module tb_led_strip_renderer;
  localparam int NLED = 4;
  logic clk = 1'b0, reset = 1'b1, refresh = 1'b0;
  logic [1:0] red_cur_pos = '0, blue_cur_pos = '0, green_cur_pos = '0, yellow_cur_pos = '0;
  logic red_ready_to_play = 1'b0, blue_ready_to_play = 1'b0;
  logic green_ready_to_play = 1'b0, yellow_ready_to_play = 1'b0;
  logic is_in_menu = 1'b0;
  logic [2:0] countdown = '0;
  logic led_data, busy;
  int total = 0, passed = 0, failed = 0;
  int pos [4], rdy [4], menu, cd;
  int s_pos [4], s_rdy [4], s_menu, s_cd;

  always #5 clk = ~clk;

  led_strip_renderer #(
    .MAX_POS(NLED), .BIT_CLK_COUNT(10), .T0H_CLK_COUNT(3), .T1H_CLK_COUNT(6), .RESET_CLK_COUNT(20)
  ) dut (
    .clk(clk), .reset(reset),
    .red_cur_pos(red_cur_pos), .blue_cur_pos(blue_cur_pos),
    .green_cur_pos(green_cur_pos), .yellow_cur_pos(yellow_cur_pos),
    .red_ready_to_play(red_ready_to_play), .blue_ready_to_play(blue_ready_to_play),
    .green_ready_to_play(green_ready_to_play), .yellow_ready_to_play(yellow_ready_to_play),
    .is_in_menu(is_in_menu), .countdown(countdown), .refresh(refresh),
    .led_data(led_data), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] color(input int p);
    case (p)
      0: return 24'h004000;
      1: return 24'h000040;
      2: return 24'h400000;
      default: return 24'h404000;
    endcase
  endfunction

  function automatic logic [23:0] model(input int i);
    logic [23:0] w = 24'h0;
    bit found = 0;
    int lit;
    if (s_menu == 0) begin
      for (int p = 0; p < 4; p++)
        if (s_pos[p] == i) begin
`ifdef LED_COLOR_BLEND_EN
          w = w | color(p);
`else
          if (!found) w = color(p);
`endif
          found = 1;
        end
    end else begin
      lit = s_cd < NLED ? s_cd : NLED;
      if (i < 4 && s_rdy[i] != 0) w = color(i);
      if (i >= NLED - lit) w = 24'h404040;
    end
    return w;
  endfunction

  task automatic apply();
    red_cur_pos = 2'(pos[0]); blue_cur_pos = 2'(pos[1]);
    green_cur_pos = 2'(pos[2]); yellow_cur_pos = 2'(pos[3]);
    red_ready_to_play = rdy[0] != 0; blue_ready_to_play = rdy[1] != 0;
    green_ready_to_play = rdy[2] != 0; yellow_ready_to_play = rdy[3] != 0;
    is_in_menu = menu != 0; countdown = 3'(cd);
  endtask

  task automatic take_snap();
    s_pos = pos; s_rdy = rdy; s_menu = menu; s_cd = cd;
  endtask

  task automatic pulse_refresh();
    apply();
    take_snap();
    @(negedge clk);
    chk("idle_busy", busy, 0);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    chk("latch_busy", busy, 1);
    chk("latch_led_low", led_data, 0);
  endtask

  // decodes a whole frame; optionally pulses refresh three times mid-frame with a new red position
  task automatic run_frame(input int inj_bit, input int inj_pos);
    logic [23:0] got [NLED];
    logic [23:0] exp [NLED];
    int hi, bad = 0;
    for (int l = 0; l < NLED; l++) exp[l] = model(l);
    for (int b = 0; b < NLED * 24; b++) begin
      hi = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (inj_bit >= 0 && c == 0 && (b == inj_bit || b == inj_bit + 3 || b == inj_bit + 6)) begin
          refresh = 1'b1;
          pos[0] = inj_pos;
          apply();
        end else refresh = 1'b0;
        if (led_data === 1'b1) begin
          if (hi != c) bad++;
          hi++;
        end
      end
      if (hi != 3 && hi != 6) bad++;
      got[b / 24] = {got[b / 24][22:0], hi == 6};
    end
    refresh = 1'b0;
    chk("bit_shape_errors", bad, 0);
    for (int l = 0; l < NLED; l++) chk($sformatf("led%0d_word", l), {8'h0, got[l]}, {8'h0, exp[l]});
  endtask

  task automatic gap_check(input logic after);
    int bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (led_data !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("gap_shape_errors", bad, 0);
    @(negedge clk);
    chk("after_gap_busy", busy, after);
    chk("after_gap_led", led_data, 0);
  endtask

  task automatic boot_window();
    int nb = 0, nl = 0;
    repeat (40) begin
      @(negedge clk);
      nb += int'(busy);
      nl += int'(led_data);
    end
    chk("boot_busy_cycles", nb, 20);
    chk("boot_led_high_cycles", nl, 0);
    chk("boot_end_busy", busy, 0);
  endtask

  initial begin
    pos = '{0, 0, 0, 0}; rdy = '{0, 0, 0, 0}; menu = 0; cd = 0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_led", led_data, 0);
      chk("reset_busy", busy, 0);
    end
    reset = 1'b0;
    boot_window();
    // directed race: red on 2, everyone else stacked on 0
    pos = '{2, 0, 0, 0};
    pulse_refresh(); run_frame(-1, 0); gap_check(1'b0);
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 4; p++) pos[p] = int'($urandom_range(0, 3));
      pulse_refresh(); run_frame(-1, 0); gap_check(1'b0);
    end
    // directed menu: only blue ready, countdown 2
    menu = 1; rdy = '{0, 1, 0, 0}; cd = 2;
    pulse_refresh(); run_frame(-1, 0); gap_check(1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 4; p++) rdy[p] = int'($urandom_range(0, 1));
      cd = int'($urandom_range(0, 7));
      pulse_refresh(); run_frame(-1, 0); gap_check(1'b0);
    end
    // coalescing: three mid-frame requests give exactly one follow-up frame with the new position
    menu = 0; pos = '{1, 3, 3, 3};
    pulse_refresh(); run_frame(20, 2); gap_check(1'b1);
    take_snap(); run_frame(-1, 0); gap_check(1'b0);
    // reset in the middle of bit 30
    pos = '{0, 1, 2, 3};
    pulse_refresh();
    repeat (301) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_led", led_data, 0);
    chk("midreset_busy", busy, 0);
    reset = 1'b0;
    boot_window();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
